// File: rtl/ah_rr_arb_mux.sv
// ah_rr_arb_mux: N:1 valid/ready packet mux with round-robin arbitration.
// Merges demuxed egress streams back into one registered stream, tagging
// every beat with the ingress index that supplied it.
// Build option: define AH_RR_ARB_MUX_PKT_LOCK_EN to hold the grant for a whole
// packet (IDLE/LOCKED FSM). Left undefined, arbitration runs every beat.
module ah_rr_arb_mux #(
  parameter int DATA_W = 109,
  parameter int N_ING  = 24,
  parameter int SEL_W  = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_ING*DATA_W-1:0] ing_data,
  input  logic [N_ING-1:0]        ing_valid,
  input  logic [N_ING-1:0]        ing_last,
  output logic [N_ING-1:0]        ing_ready,
  output logic [DATA_W-1:0]       egr_data,
  output logic                    egr_valid,
  output logic                    egr_last,
  output logic [SEL_W-1:0]        egr_src,
  input  logic                    egr_ready
);

  logic [N_ING-1:0][DATA_W-1:0] ing_vec;
  logic [SEL_W-1:0]             rr_ptr;
  logic [SEL_W-1:0]             grant;
  logic                         grant_vld;
  logic [SEL_W-1:0]             sel;
  logic                         sel_vld;
  logic                         sel_last;
  logic                         out_free;
  logic                         xfer;
  logic                         rr_adv;
  logic [SEL_W-1:0]             rr_nxt;

  // view the flat ingress bus as one payload per port
  for (genvar g = 0; g < N_ING; g++) begin : g_unpack
    assign ing_vec[g] = ing_data[g*DATA_W +: DATA_W];
  end

  // single output register: it can take a beat when empty or draining
  assign out_free = !egr_valid || egr_ready;

  // round-robin scan starting at rr_ptr, wrapping modulo N_ING
  always_comb begin
    int               idx;
    logic [SEL_W-1:0] idx_s;
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    idx_s     = '0;
    for (int k = 0; k < N_ING; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_ING) idx = idx - N_ING;
      idx_s = SEL_W'(idx);
      if (!grant_vld && ing_valid[idx_s]) begin
        grant_vld = 1'b1;
        grant     = idx_s;
      end
    end
  end

`ifdef AH_RR_ARB_MUX_PKT_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t           state_q, state_d;
  logic [SEL_W-1:0] lock_idx;

  // FSM state register and the port that owns the packet in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lock_idx <= '0;
    end else begin
      state_q <= state_d;
      if (xfer && state_q == IDLE) lock_idx <= grant;
    end
  end

  // selection, ready and next state; LOCKED serves only lock_idx even
  // when its valid drops mid-packet
  always_comb begin
    state_d   = state_q;
    sel       = grant;
    sel_vld   = grant_vld;
    ing_ready = '0;
    if (state_q == LOCKED) begin
      sel     = lock_idx;
      sel_vld = ing_valid[lock_idx];
      if (rst_n) ing_ready[lock_idx] = out_free;
    end else if (grant_vld && rst_n) begin
      ing_ready[grant] = out_free;
    end
    xfer     = rst_n && sel_vld && out_free;
    sel_last = ing_last[sel];
    case (state_q)
      IDLE:    if (xfer && !sel_last) state_d = LOCKED;
      LOCKED:  if (xfer &&  sel_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rr_adv = xfer && sel_last;
  end
`else
  // per-beat arbitration: the current grant is always the selected port
  always_comb begin
    sel       = grant;
    sel_vld   = grant_vld;
    ing_ready = '0;
    if (grant_vld && rst_n) ing_ready[grant] = out_free;
    xfer      = rst_n && sel_vld && out_free;
    sel_last  = ing_last[sel];
    rr_adv    = xfer;
  end
`endif

  assign rr_nxt = (sel == SEL_W'(N_ING - 1)) ? '0 : sel + SEL_W'(1);

  // round-robin pointer moves just past the port that was served
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rr_ptr <= '0;
    else if (rr_adv) rr_ptr <= rr_nxt;
  end

  // output register: load on transfer, clear valid once drained, hold on stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      egr_valid <= 1'b0;
      egr_data  <= '0;
      egr_last  <= 1'b0;
      egr_src   <= '0;
    end else if (xfer) begin
      egr_valid <= 1'b1;
      egr_data  <= ing_vec[sel];
      egr_last  <= sel_last;
      egr_src   <= sel;
    end else if (egr_ready) begin
      egr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ah_rr_arb_mux.sv
// Directed bench for ah_rr_arb_mux: per-port source queues drive the ingress
// side, hand-computed expected beats go into a scoreboard queue, and a
// negedge monitor pops and compares every accepted egress beat.
module tb_ah_rr_arb_mux;
  localparam int DATA_W = 109;
  localparam int N_ING  = 24;
  localparam int SEL_W  = 5;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  typedef struct packed {
    logic [SEL_W-1:0]  src;
    logic              last;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [N_ING*DATA_W-1:0] ing_data = '0;
  logic [N_ING-1:0]        ing_valid = '0;
  logic [N_ING-1:0]        ing_last = '0;
  logic [N_ING-1:0]        ing_ready;
  logic [DATA_W-1:0]       egr_data;
  logic                    egr_valid;
  logic                    egr_last;
  logic [SEL_W-1:0]        egr_src;
  logic                    egr_ready = 1'b1;

  beat_t pq[N_ING][$];
  exp_t  eq[$];
  int    checks = 0;
  int    errors = 0;

  ah_rr_arb_mux #(.DATA_W(DATA_W), .N_ING(N_ING), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ing_data(ing_data), .ing_valid(ing_valid), .ing_last(ing_last),
    .ing_ready(ing_ready),
    .egr_data(egr_data), .egr_valid(egr_valid), .egr_last(egr_last),
    .egr_src(egr_src), .egr_ready(egr_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic put(input int p, input logic [DATA_W-1:0] d, input logic l);
    pq[p].push_back('{last: l, data: d});
  endtask

  task automatic expb(input int s, input logic [DATA_W-1:0] d, input logic l);
    eq.push_back('{src: SEL_W'(s), last: l, data: d});
  endtask

  // present the head of each port queue
  task automatic drive();
    for (int i = 0; i < N_ING; i++) begin
      if (pq[i].size() > 0) begin
        ing_valid[i] = 1'b1;
        ing_data[i*DATA_W +: DATA_W] = pq[i][0].data;
        ing_last[i] = pq[i][0].last;
      end else begin
        ing_valid[i] = 1'b0;
        ing_data[i*DATA_W +: DATA_W] = '0;
        ing_last[i] = 1'b0;
      end
    end
  endtask

  // one clock: sample handshakes at negedge, advance sources after posedge
  task automatic step();
    logic [N_ING-1:0] fired;
    @(negedge clk);
    fired = ing_valid & ing_ready;
    chk("ready_onehot", 128'($countones(ing_ready) <= 1), 128'(1));
    @(posedge clk);
    #1;
    for (int i = 0; i < N_ING; i++)
      if (fired[i] && pq[i].size() > 0) void'(pq[i].pop_front());
    drive();
  endtask

  task automatic drain(output int n);
    n = 0;
    while (eq.size() > 0 && n < 500) begin
      step();
      n++;
    end
    chk("drain_done", 128'(eq.size()), 128'(0));
  endtask

  // scoreboard monitor: every accepted egress beat must match the next expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && egr_valid && egr_ready) begin
      checks++;
      if (eq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: src %0d data %0h with nothing expected", egr_src, egr_data);
      end else begin
        e = eq.pop_front();
        if (egr_src !== e.src || egr_data !== e.data || egr_last !== e.last) begin
          errors++;
          $display("FAIL beat: got src %0d last %0b data %0h want src %0d last %0b data %0h",
                   egr_src, egr_last, egr_data, e.src, e.last, e.data);
        end
      end
    end
  end

  initial begin
    int n;

    // reset with every port valid: nothing accepted, outputs cleared
    for (int i = 0; i < N_ING; i++) put(i, DATA_W'(32'h100 + i), 1'b1);
    drive();
    repeat (3) @(negedge clk);
    chk("rst_egr_valid", 128'(egr_valid), 128'(0));
    chk("rst_ing_ready", 128'(ing_ready), 128'(0));
    chk("rst_egr_data",  128'(egr_data),  128'(0));
    chk("rst_egr_src",   128'(egr_src),   128'(0));
    chk("rst_egr_last",  128'(egr_last),  128'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    // first grant is port 0, then strictly ascending to 23 (leaves rr_ptr=0)
    for (int i = 0; i < N_ING; i++) expb(i, DATA_W'(32'h100 + i), 1'b1);
    drain(n);

    // fairness: ports 0,3,23 always valid, 1-cycle latency then 1 beat/cycle
    for (int r = 0; r < 2; r++) begin
      put(0,  DATA_W'(32'h0A0 + r), 1'b1);
      put(3,  DATA_W'(32'h3A0 + r), 1'b1);
      put(23, DATA_W'(32'h17A0 + r), 1'b1);
    end
    for (int r = 0; r < 2; r++) begin
      expb(0,  DATA_W'(32'h0A0 + r), 1'b1);
      expb(3,  DATA_W'(32'h3A0 + r), 1'b1);
      expb(23, DATA_W'(32'h17A0 + r), 1'b1);
    end
    drive();
    drain(n);
    chk("fair_cycles", 128'(n), 128'(7));

    // wrap: port 22 alone sets rr_ptr=23, then 23 wins and the scan wraps to 0
    put(22, DATA_W'(32'h2200), 1'b1);
    expb(22, DATA_W'(32'h2200), 1'b1);
    drive();
    drain(n);
    put(23, DATA_W'(32'h2300), 1'b1);
    put(0,  DATA_W'(32'h0B00), 1'b1);
    put(1,  DATA_W'(32'h0B01), 1'b1);
    expb(23, DATA_W'(32'h2300), 1'b1);
    expb(0,  DATA_W'(32'h0B00), 1'b1);
    expb(1,  DATA_W'(32'h0B01), 1'b1);
    drive();
    drain(n);

    // packet lock: ports 5 and 6 each send a 4-beat packet (rr_ptr=2)
    for (int b = 0; b < 4; b++) begin
      put(5, DATA_W'(32'h500 + b), 1'(b == 3));
      put(6, DATA_W'(32'h600 + b), 1'(b == 3));
    end
`ifdef AH_RR_ARB_MUX_PKT_LOCK_EN
    for (int b = 0; b < 4; b++) expb(5, DATA_W'(32'h500 + b), 1'(b == 3));
    for (int b = 0; b < 4; b++) expb(6, DATA_W'(32'h600 + b), 1'(b == 3));
`else
    for (int b = 0; b < 4; b++) begin
      expb(5, DATA_W'(32'h500 + b), 1'(b == 3));
      expb(6, DATA_W'(32'h600 + b), 1'(b == 3));
    end
`endif
    drive();
    drain(n);

    // backpressure: rr_ptr=7, port 9 wins with 0x1_2345 and is held 3 cycles
    put(9,  DATA_W'(32'h1_2345), 1'b1);
    put(9,  DATA_W'(32'h1_2346), 1'b1);
    put(10, DATA_W'(32'hA00), 1'b1);
    expb(9,  DATA_W'(32'h1_2345), 1'b1);
    expb(10, DATA_W'(32'hA00), 1'b1);
    expb(9,  DATA_W'(32'h1_2346), 1'b1);
    drive();
    step();
    egr_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stall_valid", 128'(egr_valid), 128'(1));
      chk("stall_data",  128'(egr_data),  128'(32'h1_2345));
      chk("stall_src",   128'(egr_src),   128'(9));
      chk("stall_ready", 128'(ing_ready), 128'(0));
    end
    egr_ready = 1'b1;
    drain(n);

    // reset mid-packet: port 12 (rr_ptr=10) sends 2 of 4 beats, then reset
    for (int b = 0; b < 4; b++) put(12, DATA_W'(32'hC00 + b), 1'(b == 3));
    for (int b = 0; b < 4; b++) expb(12, DATA_W'(32'hC00 + b), 1'(b == 3));
    drive();
    step();
    step();
    chk("pre_rst_valid", 128'(egr_valid), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(egr_valid), 128'(0));
    chk("mid_rst_ready", 128'(ing_ready), 128'(0));
    eq.delete();
    pq[12].delete();
    drive();
    @(posedge clk);
    #1 rst_n = 1'b1;
    // back in IDLE with rr_ptr=0: port 3 precedes the lower-priority port 12
    put(3,  DATA_W'(32'h300), 1'b1);
    put(12, DATA_W'(32'hC10), 1'b1);
    expb(3,  DATA_W'(32'h300), 1'b1);
    expb(12, DATA_W'(32'hC10), 1'b1);
    drive();
    drain(n);

    repeat (3) step();
    chk("final_idle", 128'(egr_valid), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
